dt_pack: RTL and testbench

- Reverse-direction companion to the distance-transform engine.
- Reads the 128x128 8-bit-per-pixel result memory and thresholds each pixel to one bit.
- Packs the bits back into the 16-bit-per-word binary image format: 1024 words, row-major, first pixel of each word at bit 15.
- Used to regenerate or compare binary images (e.g. eroded masks) from a distance map. Runs once per start pulse.

---
 rtl/dt_pack.sv | 133 +++++++++++++
 tb/tb_dt_pack.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/dt_pack.sv
// Thresholds the 128x128 8-bit result map and packs it into 1024 16-bit binary words.
// Latency: first word 17 cycles after start, done 16386 cycles after start.
// No backpressure: one read and at most one write per cycle, unconditionally.
module dt_pack #(
  parameter logic [7:0] THRESH = 8'd1,
  parameter logic       INVERT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        res_rd,
  output logic [13:0] res_addr,
  input  logic [7:0]  res_di,
  output logic        sti_wr,
  output logic [9:0]  sti_addr,
  output logic [15:0] sti_do
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DRAIN   = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        start_acc;
  logic        issue_last;
  logic        cap_vld;
  logic        cap_bit;
  logic        cap_last;
  logic        cap_seen;
  logic [13:0] cap_cnt;
  logic [14:0] word_sr;

  assign issue_last = res_rd && (res_addr == 14'h3FFF);
  assign cap_last   = (cap_cnt == 14'h3FFF);
  assign cap_bit    = (res_di >= THRESH) ^ INVERT;
  assign busy       = (state == RUN) || (state == DRAIN);
  assign done       = (state == ST_DONE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    case (state)
      IDLE, ST_DONE: begin
        if (start) begin
          state_nxt = RUN;
          start_acc = 1'b1;
        end
      end
      RUN: begin
        if (issue_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (cap_seen) begin
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Issue side: res_addr doubles as the issue counter and parks at 16383 after the pass.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_rd   <= 1'b0;
      res_addr <= 14'd0;
    end else if (start_acc) begin
      res_rd   <= 1'b1;
      res_addr <= 14'd0;
    end else if (res_rd) begin
      if (issue_last) begin
        res_rd <= 1'b0;
      end else begin
        res_addr <= res_addr + 14'd1;
      end
    end
  end

  // Memory returns data one cycle after the address; this stage lines the capture up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_vld <= 1'b0;
    end else begin
      cap_vld <= res_rd;
    end
  end

  // Only 15 bits are stored: the 16th pixel of a word goes straight to sti_do.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cap_cnt  <= 14'd0;
      cap_seen <= 1'b0;
      word_sr  <= 15'd0;
      sti_wr   <= 1'b0;
      sti_addr <= 10'd0;
      sti_do   <= 16'd0;
    end else begin
      sti_wr <= 1'b0;
      if (start_acc) begin
        cap_cnt  <= 14'd0;
        cap_seen <= 1'b0;
      end else if (cap_vld) begin
        word_sr <= {word_sr[13:0], cap_bit};
        if (cap_cnt[3:0] == 4'hF) begin
          sti_wr   <= 1'b1;
          sti_addr <= cap_cnt[13:4];
          sti_do   <= {word_sr, cap_bit};
        end
        if (cap_last) begin
          cap_seen <= 1'b1;
        end else begin
          cap_cnt <= cap_cnt + 14'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dt_pack.sv
// Directed bench for dt_pack: four parameter variants share one result memory and one start.
module tb_dt_pack;

  typedef struct packed {
    logic        vld;
    logic [1:0]  idx;
    logic [9:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  res_di;
  logic [3:0]  busy_a;
  logic [3:0]  done_a;
  logic [3:0]  rd_a;
  logic [3:0]  wr_a;
  logic [13:0] raddr_a [4];
  logic [9:0]  waddr_a [4];
  logic [15:0] wdo_a   [4];

  logic [7:0]  mem [16384];
  logic [15:0] cap [4][1024];
  int          wr_cnt [4];
  exp_t        exp_q [$];
  exp_t        mon_e;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Result memory model, read latency one cycle.
  always @(posedge clk) if (rd_a[0]) res_di <= mem[raddr_a[0]];

  dt_pack #(.THRESH(8'd1), .INVERT(1'b0)) u0 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a[0]), .done(done_a[0]),
    .res_rd(rd_a[0]), .res_addr(raddr_a[0]), .res_di(res_di),
    .sti_wr(wr_a[0]), .sti_addr(waddr_a[0]), .sti_do(wdo_a[0]));
  dt_pack #(.THRESH(8'd5), .INVERT(1'b0)) u1 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a[1]), .done(done_a[1]),
    .res_rd(rd_a[1]), .res_addr(raddr_a[1]), .res_di(res_di),
    .sti_wr(wr_a[1]), .sti_addr(waddr_a[1]), .sti_do(wdo_a[1]));
  dt_pack #(.THRESH(8'd6), .INVERT(1'b0)) u2 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a[2]), .done(done_a[2]),
    .res_rd(rd_a[2]), .res_addr(raddr_a[2]), .res_di(res_di),
    .sti_wr(wr_a[2]), .sti_addr(waddr_a[2]), .sti_do(wdo_a[2]));
  dt_pack #(.THRESH(8'd1), .INVERT(1'b1)) u3 (
    .clk(clk), .reset(reset), .start(start), .busy(busy_a[3]), .done(done_a[3]),
    .res_rd(rd_a[3]), .res_addr(raddr_a[3]), .res_di(res_di),
    .sti_wr(wr_a[3]), .sti_addr(waddr_a[3]), .sti_do(wdo_a[3]));

  function automatic logic [15:0] model(input int i, input int w);
    logic [7:0]  th;
    logic        inv;
    logic [15:0] r;
    th  = 8'd1;
    inv = 1'b0;
    case (i)
      1: th = 8'd5;
      2: th = 8'd6;
      3: inv = 1'b1;
      default: th = 8'd1;
    endcase
    r = 16'd0;
    for (int j = 0; j < 16; j++) r[15-j] = (mem[w*16+j] >= th) ^ inv;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h required=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write of every instance is popped in instance order.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_a[i]) begin
        wr_cnt[i]++;
        cap[i][waddr_a[i]] = wdo_a[i];
        if (exp_q.size() != 0) mon_e = exp_q.pop_front();
        else mon_e = '0;
        total++;
        assert ({1'b1, 2'(i), waddr_a[i], wdo_a[i]} === mon_e) else begin
          bad++;
          $error("FAIL word dut=%0d observed addr=%0d data=%h required vld=%0d addr=%0d data=%h",
                 i, waddr_a[i], wdo_a[i], mon_e.vld, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  task automatic push_exp();
    for (int w = 0; w < 1024; w++)
      for (int i = 0; i < 4; i++)
        exp_q.push_back({1'b1, 2'(i), 10'(w), model(i, w)});
    for (int i = 0; i < 4; i++) begin
      wr_cnt[i] = 0;
      for (int w = 0; w < 1024; w++) cap[i][w] = 16'hDEAD;
    end
  endtask

  task automatic run_pass(input string tag, input bit poke);
    int   c0;
    int   n;
    int   rd_err;
    int   busy_err;
    logic exp_rd;
    push_exp();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    c0 = cyc;
    chk({tag, "_accept"}, {busy_a, done_a}, {4'hF, 4'h0});
    n = 0;
    rd_err = 0;
    busy_err = 0;
    while (!done_a[0] && n < 20000) begin
      exp_rd = (n <= 16383);
      if (rd_a !== {4{exp_rd}} || (exp_rd && raddr_a[0] !== 14'(n))) rd_err++;
      if (busy_a !== 4'hF || done_a !== 4'h0) busy_err++;
      start = (poke && n == 100);
      @(negedge clk);
      n = cyc - c0;
    end
    start = 1'b0;
    chk({tag, "_done_latency"}, n, 16386);
    chk({tag, "_rd_sequence_errs"}, rd_err, 0);
    chk({tag, "_busy_errs"}, busy_err, 0);
    chk({tag, "_done_state"}, {busy_a, done_a, rd_a}, {4'h0, 4'hF, 4'h0});
    chk({tag, "_addr_park"}, raddr_a[0], 14'h3FFF);
    chk({tag, "_left_in_queue"}, exp_q.size(), 0);
    for (int i = 0; i < 4; i++) chk({tag, "_write_count"}, wr_cnt[i], 1024);
  endtask

  initial begin
    logic [3:0] seen;
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {busy_a, done_a, rd_a, wr_a}, 16'h0);
    chk("reset_addr", {raddr_a[0], waddr_a[0]}, 24'h0);
    chk("reset_do", wdo_a[0], 16'h0);
    reset = 1'b1;

    for (int k = 0; k < 16384; k++) mem[k] = 8'd0;
    run_pass("all_zero", 1'b0);
    chk("all_zero_w0", cap[0][0], 16'h0000);
    chk("all_zero_w1023", cap[0][1023], 16'h0000);
    chk("all_zero_inv_w5", cap[3][5], 16'hFFFF);

    // Ramp pass carries a start pulse while busy; the next pass is started from DONE.
    for (int k = 0; k < 16384; k++) mem[k] = 8'(k % 256);
    run_pass("ramp", 1'b1);
    chk("ramp_w0", cap[0][0], 16'h7FFF);
    chk("ramp_w1", cap[0][1], 16'hFFFF);
    chk("ramp_w16", cap[0][16], 16'h7FFF);
    chk("ramp_w17", cap[0][17], 16'hFFFF);

    for (int k = 0; k < 16384; k++) mem[k] = 8'd0;
    mem[17] = 8'd5;
    run_pass("single", 1'b0);
    chk("single_t5_w1", cap[1][1], 16'h4000);
    chk("single_t5_w0", cap[1][0], 16'h0000);
    chk("single_t6_w1", cap[2][1], 16'h0000);

    for (int k = 0; k < 16384; k++) mem[k] = 8'd3;
    run_pass("inv_three", 1'b0);
    chk("inv_three_w0", cap[3][0], 16'h0000);
    chk("inv_three_w1023", cap[3][1023], 16'h0000);
    chk("inv_three_plain_w500", cap[0][500], 16'hFFFF);

    // Abort a pass with reset after 500 cycles, then run a clean one.
    for (int k = 0; k < 16384; k++) mem[k] = 8'(k % 256);
    push_exp();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (500) @(negedge clk);
    chk("pre_abort_busy", busy_a, 4'hF);
    #2 reset = 1'b0;
    #1;
    chk("abort_ctl", {busy_a, done_a, rd_a, wr_a}, 16'h0);
    chk("abort_addr", {raddr_a[0], waddr_a[0]}, 24'h0);
    chk("abort_do", wdo_a[0], 16'h0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    seen = 4'h0;
    repeat (40) begin
      @(negedge clk);
      seen |= wr_a;
    end
    chk("post_abort_silent", {seen, busy_a, done_a}, 12'h0);
    run_pass("post_abort", 1'b0);
    chk("post_abort_w0", cap[0][0], 16'h7FFF);
    chk("post_abort_w16", cap[0][16], 16'h7FFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
